// File: rtl/mmio_uart_hub.sv
// Memory/MMIO hub between the core data port, BRAM/DDR2 and the UART.
// Normal accesses are routed by address; MMIO accesses are served from an RX word FIFO and a TX byte FIFO.
module mmio_uart_hub #(
  parameter logic [31:0] CODE_SECTION_SIZE = 32'h5000,
  parameter int          RX_DEPTH          = 512,
  parameter int          TX_DEPTH          = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic [31:0] req_rd,
  output logic [31:0] req_rd_mmio,
  output logic        req_stall,
  output logic        bram_en,
  output logic        bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wd,
  input  logic [31:0] bram_rd,
  input  logic        bram_stall,
  output logic        ddr_en,
  output logic        ddr_we,
  output logic [31:0] ddr_addr,
  output logic [31:0] ddr_wd,
  input  logic [31:0] ddr_rd,
  input  logic        ddr_stall,
  output logic        tx_start,
  output logic [7:0]  sdata,
  input  logic        tx_busy
);

  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int RXCW = RXAW + 1;
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int TXCW = TXAW + 1;

  localparam logic [RXAW-1:0] RX_PTR_ONE = RXAW'(1);
  localparam logic [RXCW-1:0] RX_CNT_ONE = RXCW'(1);
  localparam logic [RXCW-1:0] RX_FULL    = RXCW'(RX_DEPTH);
  localparam logic [TXAW-1:0] TX_PTR_ONE = TXAW'(1);
  localparam logic [TXCW-1:0] TX_CNT_ONE = TXCW'(1);
  localparam logic [TXCW-1:0] TX_FULL    = TXCW'(TX_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_BUSY
  } txState_e;

  logic memAcc, codeHit, mmioAcc, mmioRd;
  logic rdSel_q;

  logic [31:0]     rxMem [RX_DEPTH];
  logic [RXAW-1:0] rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic [RXCW-1:0] rxCount_q, rxCount_d;
  logic            rxOvf_q, rxOvf_d;
  logic            rxEmpty, rxFull, rxPop, rxOverwrite;

  logic [7:0]      txMem [TX_DEPTH];
  logic [TXAW-1:0] txWr_q, txWr_d, txRd_q, txRd_d;
  logic [TXCW-1:0] txCount_q, txCount_d;
  logic            txOvf_q, txOvf_d;
  logic            txFull, txPushReq, txPush, txDrop, txPop;

  logic            statusRd;
  logic [31:0]     rdMmio;

  txState_e        txState_q;
  logic            txStart_q;
  logic [7:0]      sdata_q;

  assign memAcc  = req_en & ~req_addr[31];
  assign mmioAcc = req_en & req_addr[31];
  assign mmioRd  = mmioAcc & ~req_we;
  assign codeHit = req_addr < CODE_SECTION_SIZE;

  assign bram_en   = memAcc & codeHit;
  assign ddr_en    = memAcc & ~codeHit;
  assign bram_we   = req_we;
  assign ddr_we    = req_we;
  assign bram_addr = req_addr;
  assign ddr_addr  = req_addr;
  assign bram_wd   = req_wd;
  assign ddr_wd    = req_wd;
  assign req_stall = bram_stall | ddr_stall;
  assign req_rd    = rdSel_q ? bram_rd : ddr_rd;

  assign rxEmpty     = (rxCount_q == '0);
  assign rxFull      = (rxCount_q == RX_FULL);
  assign rxPop       = mmioRd & req_addr[0] & ~rxEmpty;
  assign rxOverwrite = rx_valid & rxFull & ~rxPop;
  assign statusRd    = mmioRd & req_addr[4];

  assign txFull    = (txCount_q == TX_FULL);
  assign txPushReq = mmioAcc & req_we & req_addr[2];
  assign txPush    = txPushReq & ~txFull;
  assign txDrop    = txPushReq & txFull;
  assign txPop     = (txState_q == TX_IDLE) & (txCount_q != '0) & ~tx_busy;

  always_comb begin
    rxWr_d    = rxWr_q;
    rxRd_d    = rxRd_q;
    rxCount_d = rxCount_q;
    rxOvf_d   = rxOvf_q;
    if (rx_valid) rxWr_d = rxWr_q + RX_PTR_ONE;
    // A push into a full FIFO drops the oldest word by moving the head along with the tail.
    if (rxPop || rxOverwrite) rxRd_d = rxRd_q + RX_PTR_ONE;
    if (rx_valid && !rxPop && !rxFull) rxCount_d = rxCount_q + RX_CNT_ONE;
    else if (!rx_valid && rxPop) rxCount_d = rxCount_q - RX_CNT_ONE;
    if (statusRd) rxOvf_d = 1'b0;
    if (rxOverwrite) rxOvf_d = 1'b1;
  end

  always_comb begin
    txWr_d    = txWr_q;
    txRd_d    = txRd_q;
    txCount_d = txCount_q;
    txOvf_d   = txOvf_q;
    if (txPush) txWr_d = txWr_q + TX_PTR_ONE;
    if (txPop) txRd_d = txRd_q + TX_PTR_ONE;
    if (txPush && !txPop) txCount_d = txCount_q + TX_CNT_ONE;
    else if (!txPush && txPop) txCount_d = txCount_q - TX_CNT_ONE;
    if (statusRd) txOvf_d = 1'b0;
    if (txDrop) txOvf_d = 1'b1;
  end

  always_comb begin
    rdMmio = '0;
    if (mmioRd) begin
      if (req_addr[0] && !rxEmpty) rdMmio = rdMmio | rxMem[rxRd_q];
      if (req_addr[1]) rdMmio = rdMmio | 32'(rxCount_q);
      if (req_addr[3]) rdMmio = rdMmio | 32'(TX_FULL - txCount_q);
      if (req_addr[4]) rdMmio = rdMmio | {30'b0, txOvf_q, rxOvf_q};
    end
  end

  assign req_rd_mmio = rdMmio;

  always_ff @(posedge clock) begin
    if (rx_valid) rxMem[rxWr_q] <= rx_data;
    if (txPush) txMem[txWr_q] <= req_wd[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdSel_q   <= 1'b1;
      rxWr_q    <= '0;
      rxRd_q    <= '0;
      rxCount_q <= '0;
      rxOvf_q   <= 1'b0;
      txWr_q    <= '0;
      txRd_q    <= '0;
      txCount_q <= '0;
      txOvf_q   <= 1'b0;
    end else begin
      if (memAcc) rdSel_q <= codeHit;
      rxWr_q    <= rxWr_d;
      rxRd_q    <= rxRd_d;
      rxCount_q <= rxCount_d;
      rxOvf_q   <= rxOvf_d;
      txWr_q    <= txWr_d;
      txRd_q    <= txRd_d;
      txCount_q <= txCount_d;
      txOvf_q   <= txOvf_d;
    end
  end

  // START waits for UartTx to raise busy so a stale low busy cannot trigger a second byte.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      txState_q <= TX_IDLE;
      txStart_q <= 1'b0;
      sdata_q   <= 8'h00;
    end else begin
      case (txState_q)
        TX_IDLE: begin
          txStart_q <= 1'b0;
          if (txPop) begin
            sdata_q   <= txMem[txRd_q];
            txStart_q <= 1'b1;
            txState_q <= TX_START;
          end
        end
        TX_START: begin
          txStart_q <= 1'b0;
          if (tx_busy) txState_q <= TX_BUSY;
        end
        TX_BUSY: begin
          txStart_q <= 1'b0;
          if (!tx_busy) txState_q <= TX_IDLE;
        end
        default: begin
          txStart_q <= 1'b0;
          txState_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_start = txStart_q;
  assign sdata    = sdata_q;

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Scoreboard bench for mmio_uart_hub: stimulus queues expected responses,
// a negedge monitor pops and compares whenever the DUT presents a read, a routed access or a tx_start.
module tb_mmio_uart_hub;

  localparam logic [31:0] BRAMV = 32'hB0B0_0001;
  localparam logic [31:0] DDRV  = 32'hD0D0_0002;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        req_en = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wd = '0;
  logic [31:0] req_rd, req_rd_mmio;
  logic        req_stall;
  logic        bram_en, bram_we, ddr_en, ddr_we;
  logic [31:0] bram_addr, bram_wd, ddr_addr, ddr_wd;
  logic [31:0] bram_rd = BRAMV;
  logic [31:0] ddr_rd = DDRV;
  logic        bram_stall = 1'b0;
  logic        ddr_stall = 1'b0;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;

  always #5 clock = ~clock;

  mmio_uart_hub dut (
    .clock(clock), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_wd(req_wd),
    .req_rd(req_rd), .req_rd_mmio(req_rd_mmio), .req_stall(req_stall),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wd(bram_wd),
    .bram_rd(bram_rd), .bram_stall(bram_stall),
    .ddr_en(ddr_en), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_wd(ddr_wd),
    .ddr_rd(ddr_rd), .ddr_stall(ddr_stall),
    .tx_start(tx_start), .sdata(sdata), .tx_busy(tx_busy)
  );

  // UartTx stand-in: busy for 10 cycles after each start, or forced busy by holdBusy.
  int   busyCnt = 0;
  logic holdBusy = 1'b0;
  always @(posedge clock) begin
    if (tx_start) busyCnt <= 10;
    else if (busyCnt > 0) busyCnt <= busyCnt - 1;
  end
  assign tx_busy = (busyCnt != 0) || holdBusy;

  typedef struct {
    string       name;
    logic [31:0] value;
    bit          chkRd;
    logic [31:0] rd;
  } exp_t;

  exp_t mmioQ[$];
  exp_t memQ[$];
  exp_t txQ[$];
  exp_t probeQ[$];

  logic probe = 1'b0;
  logic finishReq = 1'b0;
  logic finishAck = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: unexpected DUT output 0x%08h with nothing expected", name, act);
  endtask

  // Monitor: every DUT-presented event consumes one queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (req_en && req_addr[31] && !req_we) begin
      if (mmioQ.size() == 0) reportUnexpected("mmio_read", req_rd_mmio);
      else begin
        e = mmioQ.pop_front();
        checkOutput(e.name, req_rd_mmio, e.value);
        if (e.chkRd) checkOutput({e.name, "_req_rd"}, req_rd, e.rd);
      end
      checkOutput("mmio_no_mem_en", {30'b0, bram_en, ddr_en}, 32'h0);
    end
    if (req_en && !req_addr[31]) begin
      if (memQ.size() == 0) reportUnexpected("mem_access", {30'b0, bram_en, ddr_en});
      else begin
        e = memQ.pop_front();
        checkOutput(e.name, {30'b0, bram_en, ddr_en}, e.value);
      end
    end
    if (tx_start) begin
      if (txQ.size() == 0) reportUnexpected("tx_start", {24'b0, sdata});
      else begin
        e = txQ.pop_front();
        checkOutput(e.name, {24'b0, sdata}, e.value);
        checkOutput({e.name, "_busy_low"}, {31'b0, tx_busy}, 32'h0);
      end
    end
    if (probe) begin
      if (probeQ.size() == 0) reportUnexpected("probe", {23'b0, tx_start, sdata});
      else begin
        e = probeQ.pop_front();
        checkOutput(e.name, {23'b0, tx_start, sdata}, e.value);
      end
    end
    if (finishReq && !finishAck) begin
      checkOutput("leftover_mmio", 32'(mmioQ.size()), 32'h0);
      checkOutput("leftover_mem", 32'(memQ.size()), 32'h0);
      checkOutput("leftover_tx", 32'(txQ.size()), 32'h0);
      checkOutput("leftover_probe", 32'(probeQ.size()), 32'h0);
      finishAck = 1'b1;
    end
  end

  task automatic applyStimulus(input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    req_en   = en;
    req_we   = we;
    req_addr = addr;
    req_wd   = wd;
    @(posedge clock);
    #1;
    req_en   = 1'b0;
    req_we   = 1'b0;
    req_addr = '0;
    req_wd   = '0;
  endtask

  task automatic mmioRead(input logic [4:0] bits, input logic [31:0] expv, input string name,
                          input bit chk = 1'b0, input logic [31:0] rdv = '0);
    exp_t e;
    e.name = name; e.value = expv; e.chkRd = chk; e.rd = rdv;
    mmioQ.push_back(e);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000 | 32'(bits), '0);
  endtask

  task automatic mmioWrite(input logic [4:0] bits, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000 | 32'(bits), data);
  endtask

  task automatic memLoad(input logic [31:0] addr, input logic [1:0] en, input string name);
    exp_t e;
    e.name = name; e.value = {30'b0, en}; e.chkRd = 1'b0; e.rd = '0;
    memQ.push_back(e);
    applyStimulus(1'b1, 1'b0, addr, '0);
  endtask

  task automatic expectTx(input logic [7:0] b, input string name);
    exp_t e;
    e.name = name; e.value = {24'b0, b}; e.chkRd = 1'b0; e.rd = '0;
    txQ.push_back(e);
  endtask

  task automatic probeCheck(input logic [8:0] v, input string name);
    exp_t e;
    e.name = name; e.value = {23'b0, v}; e.chkRd = 1'b0; e.rd = '0;
    probeQ.push_back(e);
    probe = 1'b1;
    @(posedge clock);
    #1;
    probe = 1'b0;
  endtask

  task automatic rxPush(input logic [31:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    probeCheck(9'h000, "reset_txstart_sdata");
    mmioRead(5'b00010, 32'd0, "reset_rx_count");
    mmioRead(5'b01000, 32'd16, "reset_tx_free");
    mmioRead(5'b10000, 32'd0, "reset_status");
    mmioRead(5'b00001, 32'd0, "reset_rx_empty_read");

    $display("[TB] RX FIFO basic push/pop");
    rxPush(32'hA0A0_0001);
    rxPush(32'hA0A0_0002);
    rxPush(32'hA0A0_0003);
    mmioRead(5'b00010, 32'd3, "rx_count3");
    mmioRead(5'b00001, 32'hA0A0_0001, "rx_pop_a");
    mmioRead(5'b00001, 32'hA0A0_0002, "rx_pop_b");
    mmioRead(5'b00001, 32'hA0A0_0003, "rx_pop_c");
    mmioRead(5'b00010, 32'd0, "rx_count0");
    mmioRead(5'b00001, 32'd0, "rx_pop_empty");
    mmioRead(5'b00010, 32'd0, "rx_count_after_empty_pop");
    rxPush(32'hA0A0_0004);
    mmioRead(5'b00010, 32'd1, "rx_count1");
    mmioRead(5'b00001, 32'hA0A0_0004, "rx_pop_d");

    $display("[TB] routing and rd_sel");
    memLoad(32'h0000_4FFF, 2'b10, "route_4fff_bram");
    mmioRead(5'b01000, 32'd16, "rdsel_bram_1", 1'b1, BRAMV);
    mmioRead(5'b01000, 32'd16, "rdsel_bram_2", 1'b1, BRAMV);
    memLoad(32'h0000_5000, 2'b01, "route_5000_ddr");
    mmioRead(5'b01000, 32'd16, "rdsel_ddr_1", 1'b1, DDRV);
    mmioRead(5'b00010, 32'd0, "rdsel_ddr_2", 1'b1, DDRV);

    $display("[TB] RX overflow");
    for (int i = 0; i <= 512; i++) rxPush(32'h2000_0000 + 32'(i));
    mmioRead(5'b00010, 32'd512, "rx_full_count");
    mmioRead(5'b00001, 32'h2000_0001, "rx_ovf_head");
    mmioRead(5'b10000, 32'd1, "rx_ovf_status");
    mmioRead(5'b10000, 32'd0, "rx_ovf_status_cleared");
    doReset();
    mmioRead(5'b00010, 32'd0, "rx_count_after_reset");

    $display("[TB] TX two bytes");
    expectTx(8'h41, "tx_byte_41");
    expectTx(8'h42, "tx_byte_42");
    mmioWrite(5'b00100, 32'h0000_0041);
    mmioWrite(5'b00100, 32'h0000_0042);
    idle(45);
    mmioRead(5'b01000, 32'd16, "tx_free_after_drain");

    $display("[TB] TX overflow with UartTx busy");
    holdBusy = 1'b1;
    for (int i = 0; i <= 16; i++) mmioWrite(5'b00100, 32'h60 + 32'(i));
    mmioRead(5'b01000, 32'd0, "tx_free_full");
    mmioRead(5'b10000, 32'd2, "tx_ovf_status");
    mmioRead(5'b10000, 32'd0, "tx_ovf_status_cleared");

    $display("[TB] reset during TX BUSY");
    for (int i = 0; i < 5; i++) rxPush(32'h3000_0000 + 32'(i));
    mmioRead(5'b00010, 32'd5, "rx_count5");
    expectTx(8'h60, "tx_byte_60");
    holdBusy = 1'b0;
    idle(6);
    doReset();
    probeCheck(9'h000, "post_reset_txstart_sdata");
    mmioRead(5'b00010, 32'd0, "post_reset_rx_count");
    mmioRead(5'b01000, 32'd16, "post_reset_tx_free");
    mmioRead(5'b10000, 32'd0, "post_reset_status");
    idle(20);
    expectTx(8'h55, "tx_byte_55");
    mmioWrite(5'b00100, 32'h0000_0055);
    idle(25);
    mmioRead(5'b01000, 32'd16, "final_tx_free");

    finishReq = 1'b1;
    for (int i = 0; i < 10 && !finishAck; i++) @(posedge clock);
    if (!finishAck) begin
      $display("[TB] FAIL finish_handshake: monitor did not acknowledge");
      $fatal(1, "[TB] monitor stalled");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
